kbd_num_entry: RTL and testbench

- Parametrised keyboard number-entry engine between the PS/2 keyboard decoder (key_state/key_ascii) and the 7-segment display/CPU input path.
- Buffers typed digits with edit keys (backspace, clear, sign, radix toggle) and exposes the raw digit buffer for live display.
- On Enter, runs a multi-cycle conversion FSM producing a WIDTH-bit binary value with saturation and overflow flag, signalled by a one-cycle valid pulse.

---
 rtl/kbd_num_entry.sv | 193 +++++++++++++++++++
 tb/tb_kbd_num_entry.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_num_entry.sv
// Keyboard number-entry engine: buffers typed digits with edit keys, then converts
// the buffer to a saturating WIDTH-bit binary value, one digit per clock.
module kbd_num_entry #(
    parameter int MAX_DIGITS  = 8,
    parameter int WIDTH       = 32,
    parameter bit HEX_DEFAULT = 1'b1
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic                             key_state,
    input  logic [7:0]                       key_ascii,
    output logic [4*MAX_DIGITS-1:0]          entry_disp,
    output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
    output logic                             radix_hex,
    output logic                             neg,
    output logic                             busy,
    output logic [WIDTH-1:0]                 value,
    output logic                             value_valid,
    output logic                             overflow,
    output logic                             key_err
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int AW = WIDTH + 5;
    localparam int BW = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {S_EDIT, S_CONVERT, S_DONE} state_t;
    state_t state, state_next;

    logic          key_prev;
    logic          key_evt;
    logic [BW-1:0] buf_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_m1;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_mul;
    logic [AW-1:0] acc_next;
    logic [AW-1:0] limit;
    logic          sat_q;
    logic          radix_q;
    logic          neg_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] result;
    logic          ovf_q;
    logic          err_q;
    logic          is_num;
    logic          is_letter;
    logic          is_digit;
    logic [3:0]    key_nib;
    logic [3:0]    cur_digit;

    // One key event per press: rising edge of the decoder's level.
    assign key_evt = key_state & ~key_prev;

    always_comb begin
        is_num    = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
        is_letter = ((key_ascii >= 8'h41) && (key_ascii <= 8'h46)) ||
                    ((key_ascii >= 8'h61) && (key_ascii <= 8'h66));
        is_digit  = is_num | (is_letter & radix_q);
        // 'A'/'a' have low nibble 1, so +9 maps letters onto 10..15.
        key_nib   = is_num ? key_ascii[3:0] : key_ascii[3:0] + 4'd9;
    end

    always_comb begin
        if (radix_q)
            limit = {5'b0, {WIDTH{1'b1}}};
        else if (neg_q)
            limit = AW'(1) << (WIDTH - 1);
        else
            limit = (AW'(1) << (WIDTH - 1)) - AW'(1);
    end

    always_comb begin
        idx_m1    = idx_q - CW'(1);
        cur_digit = 4'(buf_q >> {idx_m1, 2'b00});
        acc_mul   = radix_q ? (acc_q << 4) : ((acc_q << 3) + (acc_q << 1));
        acc_next  = acc_mul + AW'(cur_digit);
        mag       = sat_q ? limit[WIDTH-1:0] : acc_q[WIDTH-1:0];
        result    = (!radix_q && neg_q) ? (WIDTH'(0) - mag) : mag;
    end

    always_ff @(posedge clk_in) begin
        if (reset)
            state <= S_EDIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EDIT:    if (key_evt && key_ascii == 8'h0D) state_next = S_CONVERT;
            S_CONVERT: if (idx_q == '0) state_next = S_DONE;
            S_DONE:    state_next = S_EDIT;
            default:   state_next = S_EDIT;
        endcase
    end

    // value_valid is a single-cycle strobe with no back-pressure: value and
    // overflow change only on the cycle it is high and hold until the next one.
    always_comb begin
        busy        = (state == S_CONVERT);
        value_valid = (state == S_DONE);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            key_prev <= 1'b0;
            buf_q    <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            radix_q  <= HEX_DEFAULT;
            neg_q    <= 1'b0;
            value_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            key_prev <= key_state;
            err_q    <= 1'b0;
            case (state)
                S_EDIT: begin
                    if (key_evt) begin
                        if (is_digit) begin
                            if (count_q < CW'(MAX_DIGITS)) begin
                                buf_q   <= (buf_q << 4) | BW'(key_nib);
                                count_q <= count_q + CW'(1);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (is_letter) begin
                            err_q <= 1'b1;
                        end else begin
                            case (key_ascii)
                                8'h08: if (count_q != '0) begin
                                    buf_q   <= buf_q >> 4;
                                    count_q <= count_q - CW'(1);
                                end
                                8'h1B: begin
                                    buf_q   <= '0;
                                    count_q <= '0;
                                    neg_q   <= 1'b0;
                                end
                                8'h2D: if (!radix_q) neg_q <= ~neg_q;
                                       else err_q <= 1'b1;
                                8'h09: if (count_q == '0) begin
                                    radix_q <= ~radix_q;
                                    neg_q   <= 1'b0;
                                end else begin
                                    err_q <= 1'b1;
                                end
                                8'h0D: begin
                                    acc_q <= '0;
                                    sat_q <= 1'b0;
                                    idx_q <= count_q;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_CONVERT: begin
                    if (idx_q != '0) begin
                        idx_q <= idx_m1;
                        // Once saturated the accumulator freezes; the limit is output instead.
                        if (!sat_q) begin
                            if (acc_next > limit) sat_q <= 1'b1;
                            else acc_q <= acc_next;
                        end
                    end else begin
                        value_q <= result;
                        ovf_q   <= sat_q;
                        buf_q   <= '0;
                        count_q <= '0;
                        neg_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign entry_disp  = buf_q;
    assign digit_count = count_q;
    assign radix_hex   = radix_q;
    assign neg         = neg_q;
    assign value       = value_q;
    assign overflow    = ovf_q;
    assign key_err     = err_q;

endmodule

// File: tb/tb_kbd_num_entry.sv
// Bench for kbd_num_entry: directed key sequences, scoreboard of expected results
// checked by a monitor on every value_valid strobe.
module tb_kbd_num_entry;
    localparam int MAXD = 10;
    localparam int W    = 32;

    logic           clk_in = 1'b0;
    logic           reset;
    logic           key_state;
    logic [7:0]     key_ascii;
    logic [4*MAXD-1:0] entry_disp;
    logic [3:0]     digit_count;
    logic           radix_hex;
    logic           neg;
    logic           busy;
    logic [W-1:0]   value;
    logic           value_valid;
    logic           overflow;
    logic           key_err;

    kbd_num_entry #(.MAX_DIGITS(MAXD), .WIDTH(W), .HEX_DEFAULT(1'b1)) dut (
        .clk_in(clk_in), .reset(reset), .key_state(key_state), .key_ascii(key_ascii),
        .entry_disp(entry_disp), .digit_count(digit_count), .radix_hex(radix_hex),
        .neg(neg), .busy(busy), .value(value), .value_valid(value_valid),
        .overflow(overflow), .key_err(key_err)
    );

    // clock / cycle counter
    always #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // scoreboard
    logic [W:0] exp_q[$];
    int         lat_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (!reset && value_valid) begin
            check("valid_pulse_width", 64'(prev_valid), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                logic [W:0] e;
                int         l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("value", 64'(value), 64'(e[W-1:0]));
                check("overflow", 64'(overflow), 64'(e[W]));
                check("latency", 64'(cyc), 64'(l));
            end
        end
        prev_valid = value_valid;
    end

    // driver tasks (all start and end on a negedge)
    task automatic press(input logic [7:0] c, input logic exp_err);
        key_ascii = c;
        key_state = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("key_err", 64'(key_err), 64'(exp_err));
        key_state = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i], 1'b0);
    endtask

    task automatic enter(input logic [W-1:0] exp_val, input logic exp_ovf, input int n_digits);
        key_ascii = 8'h0D;
        key_state = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("busy_after_enter", 64'(busy), 64'd1);
        exp_q.push_back({exp_ovf, exp_val});
        lat_q.push_back(cyc + n_digits + 1);
        key_state = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk_in);
        check("result_timeout", 64'(exp_q.size()), 64'd0);
        check("buf_cleared", 64'(entry_disp), 64'd0);
        check("count_cleared", 64'(digit_count), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_disp"}, 64'(entry_disp), 64'd0);
        check({tag, "_count"}, 64'(digit_count), 64'd0);
        check({tag, "_radix"}, 64'(radix_hex), 64'd1);
        check({tag, "_neg"}, 64'(neg), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_value"}, 64'(value), 64'd0);
        check({tag, "_valid"}, 64'(value_valid), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_key_err"}, 64'(key_err), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        key_state = 1'b0;
        key_ascii = 8'h00;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        check_reset_state("reset");

        // hex entry
        type_str("12aF");
        check("hex_disp", 64'(entry_disp[15:0]), 64'h12AF);
        check("hex_count", 64'(digit_count), 64'd4);
        enter(32'h0000_12AF, 1'b0, 4);
        wait_done();

        // switch to decimal, negative entry, rejected keys
        press(8'h09, 1'b0);
        check("radix_dec", 64'(radix_hex), 64'd0);
        press("-", 1'b0);
        check("neg_set", 64'(neg), 64'd1);
        type_str("123");
        press("a", 1'b1);
        press(8'h09, 1'b1);
        check("radix_kept", 64'(radix_hex), 64'd0);
        check("count_kept", 64'(digit_count), 64'd3);
        enter(32'hFFFF_FF85, 1'b0, 3);
        wait_done();
        check("neg_cleared", 64'(neg), 64'd0);

        // decimal saturation and full buffer
        type_str("4294967296");
        press("1", 1'b1);
        check("full_count", 64'(digit_count), 64'd10);
        enter(32'h7FFF_FFFF, 1'b1, 10);
        wait_done();
        press("-", 1'b0);
        type_str("9999999999");
        enter(32'h8000_0000, 1'b1, 10);
        wait_done();
        type_str("2147483647");
        enter(32'h7FFF_FFFF, 1'b0, 10);
        wait_done();
        press("-", 1'b0);
        type_str("2147483648");
        enter(32'h8000_0000, 1'b0, 10);
        wait_done();
        press("-", 1'b0);
        type_str("0");
        enter(32'h0, 1'b0, 1);
        wait_done();
        enter(32'h0, 1'b0, 0);
        wait_done();

        // back to hex: backspace, escape, hex saturation
        press(8'h09, 1'b0);
        check("radix_hex_again", 64'(radix_hex), 64'd1);
        press(8'h08, 1'b0);
        check("bs_empty_count", 64'(digit_count), 64'd0);
        press("-", 1'b1);
        type_str("78");
        press(8'h08, 1'b0);
        check("bs_disp", 64'(entry_disp), 64'h7);
        type_str("9");
        check("bs_retype_disp", 64'(entry_disp), 64'h79);
        enter(32'h79, 1'b0, 2);
        wait_done();
        type_str("34");
        press(8'h1B, 1'b0);
        check("esc_disp", 64'(entry_disp), 64'd0);
        check("esc_count", 64'(digit_count), 64'd0);
        type_str("FFFFFFFF");
        enter(32'hFFFF_FFFF, 1'b0, 8);
        wait_done();
        type_str("FFFFFFFFF");
        enter(32'hFFFF_FFFF, 1'b1, 9);
        wait_done();

        // held key gives one digit; keys during conversion are discarded
        key_ascii = "5";
        key_state = 1'b1;
        repeat (50) @(negedge clk_in);
        key_state = 1'b0;
        @(negedge clk_in);
        check("hold_count", 64'(digit_count), 64'd1);
        check("hold_disp", 64'(entry_disp), 64'h5);
        type_str("1234567");
        enter(32'h5123_4567, 1'b0, 8);
        check("busy_during_keys", 64'(busy), 64'd1);
        press("9", 1'b0);
        press("-", 1'b0);
        wait_done();

        // reset during conversion
        press(8'h09, 1'b0);
        type_str("12345678");
        press(8'h0D, 1'b0);
        check("busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check_reset_state("midreset");
        reset = 1'b0;
        repeat (20) @(negedge clk_in);
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
